// File: rtl/axi_lite_slave_mem.sv
// AXI4-Lite slave memory: independent AW/W capture, byte strobes, address-window
// decode with SLVERR outside it, programmable B/R latency and a saturating error count.
//
// state  | meaning
// W_IDLE | accepting AW and W beats in either order
// W_WAIT | latency countdown; memory commit on terminal count
// W_RESP | B response presented until bready
// R_IDLE | accepting an AR beat
// R_WAIT | latency countdown; memory sample on terminal count
// R_RESP | R response presented until rready
module axi_lite_slave_mem #(
   parameter int C_S_AXI_ADDR_WIDTH = 32,
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_MEM_DEPTH        = 1024,
   parameter logic [C_S_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR = 32'h40000000,
   parameter int C_WAIT_CYCLES      = 0
) (
   input  logic                            s00_axi_aclk,
   input  logic                            s00_axi_areset,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
   input  logic [2:0]                      s00_axi_awprot,
   input  logic                            s00_axi_awvalid,
   output logic                            s00_axi_awready,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
   input  logic                            s00_axi_wvalid,
   output logic                            s00_axi_wready,
   output logic [1:0]                      s00_axi_bresp,
   output logic                            s00_axi_bvalid,
   input  logic                            s00_axi_bready,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
   input  logic [2:0]                      s00_axi_arprot,
   input  logic                            s00_axi_arvalid,
   output logic                            s00_axi_arready,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
   output logic [1:0]                      s00_axi_rresp,
   output logic                            s00_axi_rvalid,
   input  logic                            s00_axi_rready,
   output logic [15:0]                     err_cnt
);
   localparam int BYTES = C_S_AXI_DATA_WIDTH / 8;
   localparam int LSB   = $clog2(BYTES);
   localparam int IDX_W = $clog2(C_MEM_DEPTH);
   localparam logic [C_S_AXI_ADDR_WIDTH:0] WIN_SIZE = (C_S_AXI_ADDR_WIDTH+1)'(C_MEM_DEPTH * BYTES);
   localparam logic [3:0] WAIT_LOAD = 4'(C_WAIT_CYCLES);
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;
   typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;

   logic [C_S_AXI_DATA_WIDTH-1:0] mem [C_MEM_DEPTH];

   w_state_t                       w_state, w_next;
   logic                           aw_held, w_held, aw_held_d, w_held_d;
   logic                           awready_d, wready_d, bvalid_d;
   logic [C_S_AXI_ADDR_WIDTH-1:0]  aw_addr_q, w_off;
   logic [C_S_AXI_DATA_WIDTH-1:0]  w_data_q;
   logic [BYTES-1:0]               w_strb_q;
   logic [3:0]                     w_cnt;
   logic                           aw_hs, w_hs, b_hs, commit, w_in_range;
   logic [IDX_W-1:0]               w_idx;

   r_state_t                       r_state, r_next;
   logic                           arready_d, rvalid_d;
   logic [C_S_AXI_ADDR_WIDTH-1:0]  ar_addr_q, r_off;
   logic [3:0]                     r_cnt;
   logic                           ar_hs, r_hs, sample, r_in_range;
   logic [IDX_W-1:0]               r_idx;

   logic [16:0]                    err_sum;
   logic                           unused_prot;

   assign unused_prot = ^{s00_axi_awprot, s00_axi_arprot};

   // The subtraction wraps below the base, so the >= test guards the lower edge.
   assign w_off      = aw_addr_q - C_BASE_ADDR;
   assign w_in_range = (aw_addr_q >= C_BASE_ADDR) && ({1'b0, w_off} < WIN_SIZE);
   assign w_idx      = w_off[LSB +: IDX_W];
   assign r_off      = ar_addr_q - C_BASE_ADDR;
   assign r_in_range = (ar_addr_q >= C_BASE_ADDR) && ({1'b0, r_off} < WIN_SIZE);
   assign r_idx      = r_off[LSB +: IDX_W];

   assign aw_hs  = s00_axi_awvalid && s00_axi_awready;
   assign w_hs   = s00_axi_wvalid && s00_axi_wready;
   assign b_hs   = s00_axi_bvalid && s00_axi_bready;
   assign commit = (w_state == W_WAIT) && (w_cnt == 4'd0);
   assign ar_hs  = s00_axi_arvalid && s00_axi_arready;
   assign r_hs   = s00_axi_rvalid && s00_axi_rready;
   assign sample = (r_state == R_WAIT) && (r_cnt == 4'd0);

   always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
      if (s00_axi_areset) begin
         w_state <= W_IDLE;
         r_state <= R_IDLE;
      end else begin
         w_state <= w_next;
         r_state <= r_next;
      end
   end

   always_comb begin
      w_next = w_state;
      unique case (w_state)
         W_IDLE:  if ((aw_held || aw_hs) && (w_held || w_hs)) w_next = W_WAIT;
         W_WAIT:  if (w_cnt == 4'd0) w_next = W_RESP;
         W_RESP:  if (b_hs) w_next = W_IDLE;
         default: w_next = W_IDLE;
      endcase
   end

   always_comb begin
      r_next = r_state;
      unique case (r_state)
         R_IDLE:  if (ar_hs) r_next = R_WAIT;
         R_WAIT:  if (r_cnt == 4'd0) r_next = R_RESP;
         R_RESP:  if (r_hs) r_next = R_IDLE;
         default: r_next = R_IDLE;
      endcase
   end

   always_comb begin
      aw_held_d = b_hs ? 1'b0 : (aw_held || aw_hs);
      w_held_d  = b_hs ? 1'b0 : (w_held || w_hs);
      awready_d = (w_next == W_IDLE) && !aw_held_d;
      wready_d  = (w_next == W_IDLE) && !w_held_d;
      bvalid_d  = (w_next == W_RESP);
      arready_d = (r_next == R_IDLE);
      rvalid_d  = (r_next == R_RESP);
   end

   always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
      if (s00_axi_areset) begin
         aw_held         <= 1'b0;
         w_held          <= 1'b0;
         aw_addr_q       <= '0;
         w_data_q        <= '0;
         w_strb_q        <= '0;
         w_cnt           <= WAIT_LOAD;
         s00_axi_awready <= 1'b0;
         s00_axi_wready  <= 1'b0;
         s00_axi_bvalid  <= 1'b0;
         s00_axi_bresp   <= RESP_OKAY;
      end else begin
         aw_held         <= aw_held_d;
         w_held          <= w_held_d;
         s00_axi_awready <= awready_d;
         s00_axi_wready  <= wready_d;
         s00_axi_bvalid  <= bvalid_d;
         if (aw_hs) aw_addr_q <= s00_axi_awaddr;
         if (w_hs) begin
            w_data_q <= s00_axi_wdata;
            w_strb_q <= s00_axi_wstrb;
         end
         if (w_state != W_WAIT)    w_cnt <= WAIT_LOAD;
         else if (w_cnt != 4'd0)   w_cnt <= w_cnt - 4'd1;
         if (commit) s00_axi_bresp <= w_in_range ? RESP_OKAY : RESP_SLVERR;
      end
   end

   always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
      if (s00_axi_areset) begin
         ar_addr_q       <= '0;
         r_cnt           <= WAIT_LOAD;
         s00_axi_arready <= 1'b0;
         s00_axi_rvalid  <= 1'b0;
         s00_axi_rresp   <= RESP_OKAY;
         s00_axi_rdata   <= '0;
      end else begin
         s00_axi_arready <= arready_d;
         s00_axi_rvalid  <= rvalid_d;
         if (ar_hs) ar_addr_q <= s00_axi_araddr;
         if (r_state != R_WAIT)    r_cnt <= WAIT_LOAD;
         else if (r_cnt != 4'd0)   r_cnt <= r_cnt - 4'd1;
         if (sample) begin
            s00_axi_rdata <= r_in_range ? mem[r_idx] : '0;
            s00_axi_rresp <= r_in_range ? RESP_OKAY : RESP_SLVERR;
         end
      end
   end

   // Storage has no reset so it maps onto block RAM; a same-edge read sees old data.
   always_ff @(posedge s00_axi_aclk) begin
      if (commit && w_in_range) begin
         for (int b = 0; b < BYTES; b++) begin
            if (w_strb_q[b]) mem[w_idx][8*b +: 8] <= w_data_q[8*b +: 8];
         end
      end
   end

   assign err_sum = {1'b0, err_cnt} + 17'(commit && !w_in_range) + 17'(sample && !r_in_range);

   always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
      if (s00_axi_areset) err_cnt <= '0;
      else                err_cnt <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
   end
endmodule

// File: tb/tb_axi_lite_slave_mem.sv
// Bench for axi_lite_slave_mem: vector table, fill/readback, ordering, backpressure,
// same-edge read/write, reset mid-write and randomized traffic against a word-array model.
`timescale 1ns/1ps
module tb_axi_lite_slave_mem;
   localparam int          WAIT  = 3;
   localparam int          DEPTH = 1024;
   localparam logic [31:0] BASE  = 32'h40000000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
   logic [2:0]  awprot = '0, arprot = '0;
   logic [3:0]  wstrb = '0;
   logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
   logic        awready, wready, bvalid, arready, rvalid;
   logic [1:0]  bresp, rresp;
   logic [31:0] rdata;
   logic [15:0] err_cnt;

   always #5 clk = ~clk;

   axi_lite_slave_mem #(
      .C_S_AXI_ADDR_WIDTH(32), .C_S_AXI_DATA_WIDTH(32), .C_MEM_DEPTH(DEPTH),
      .C_BASE_ADDR(BASE), .C_WAIT_CYCLES(WAIT)
   ) dut (
      .s00_axi_aclk(clk), .s00_axi_areset(rst),
      .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
      .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wvalid(wvalid), .s00_axi_wready(wready),
      .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
      .s00_axi_araddr(araddr), .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
      .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid), .s00_axi_rready(rready),
      .err_cnt(err_cnt)
   );

   int vectors = 0;
   int miscompares = 0;

   logic [31:0] ref_mem [DEPTH];
   int          ref_err = 0;

   typedef struct {
      bit          is_wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [1:0]  exp_resp;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t tbl [14];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, wanted %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit ref_hit(input logic [31:0] a);
      return (a >= BASE) && (a < BASE + 32'(DEPTH * 4));
   endfunction

   function automatic void ref_bump_err();
      if (ref_err < 65535) ref_err++;
   endfunction

   function automatic logic [1:0] ref_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      int w;
      if (!ref_hit(a)) begin
         ref_bump_err();
         return 2'b10;
      end
      w = int'((a - BASE) / 4);
      for (int b = 0; b < 4; b++)
         if (s[b]) ref_mem[w][8*b +: 8] = d[8*b +: 8];
      return 2'b00;
   endfunction

   function automatic void ref_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
      if (!ref_hit(a)) begin
         ref_bump_err();
         d = 32'h0;
         r = 2'b10;
      end else begin
         d = ref_mem[int'((a - BASE) / 4)];
         r = 2'b00;
      end
   endfunction

   // Starts and ends on a falling edge. Valids go up aw_dly / w_dly cycles in.
   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly, input int b_dly,
                           output logic [1:0] resp);
      int t, lat;
      bit aw_done, w_done, aw_go, w_go, early, stable;
      logic [1:0] resp0;
      t = 0; aw_done = 0; w_done = 0; early = 0; stable = 1;
      while (!(aw_done && w_done) && t < 60) begin
         if (!aw_done && t == aw_dly) begin awaddr = a; awvalid = 1'b1; end
         if (!w_done && t == w_dly) begin wdata = d; wstrb = s; wvalid = 1'b1; end
         if ((aw_done && awready) || (w_done && wready)) early = 1;
         aw_go = awvalid && awready;
         w_go  = wvalid && wready;
         @(negedge clk); t++;
         if (aw_go) begin awvalid = 1'b0; aw_done = 1; end
         if (w_go)  begin wvalid = 1'b0;  w_done = 1;  end
      end
      awvalid = 1'b0; wvalid = 1'b0;
      check("aw_w_handshake", 64'(aw_done && w_done), 64'd1);
      lat = 0;
      while (!bvalid && lat < 40) begin
         if (awready || wready) early = 1;
         @(negedge clk); lat++;
      end
      check("b_latency", 64'(lat), 64'(WAIT + 1));
      resp = bresp; resp0 = bresp;
      for (int i = 0; i < b_dly; i++) begin
         @(negedge clk);
         if (!bvalid || bresp !== resp0 || awready || wready) stable = 0;
      end
      bready = 1'b1;
      @(negedge clk);
      bready = 1'b0;
      check("b_stable_no_early_ready", 64'({stable, early}), 64'(2'b10));
      check("aw_w_ready_after_b", 64'({awready, wready, bvalid}), 64'(3'b110));
   endtask

   task automatic do_read(input logic [31:0] a, input int r_dly,
                          output logic [31:0] data, output logic [1:0] resp);
      int t, lat;
      bit done, go, early, stable;
      logic [31:0] d0;
      logic [1:0]  r0;
      t = 0; done = 0; early = 0; stable = 1;
      araddr = a; arvalid = 1'b1;
      while (!done && t < 60) begin
         go = arready;
         @(negedge clk); t++;
         if (go) begin arvalid = 1'b0; done = 1; end
      end
      arvalid = 1'b0;
      check("ar_handshake", 64'(done), 64'd1);
      lat = 0;
      while (!rvalid && lat < 40) begin
         if (arready) early = 1;
         @(negedge clk); lat++;
      end
      check("r_latency", 64'(lat), 64'(WAIT + 1));
      data = rdata; resp = rresp; d0 = rdata; r0 = rresp;
      for (int i = 0; i < r_dly; i++) begin
         @(negedge clk);
         if (!rvalid || rdata !== d0 || rresp !== r0 || arready) stable = 0;
      end
      rready = 1'b1;
      @(negedge clk);
      rready = 1'b0;
      check("r_stable_no_early_ready", 64'({stable, early}), 64'(2'b10));
      check("ar_ready_after_r", 64'({arready, rvalid}), 64'(2'b10));
   endtask

   initial begin
      #900_000;
      $display("FAIL watchdog: simulation did not complete, got timeout, wanted finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] d, exp_d, old_d, a;
      logic [1:0]  r, exp_r, r2;
      logic [3:0]  s;
      int          e0;
      bit          saw_b;

      tbl[0]  = '{1'b1, 32'h40000010, 32'h11223344, 4'hF, 2'b00, 32'h0};
      tbl[1]  = '{1'b1, 32'h40000010, 32'hFFFFFFFF, 4'h5, 2'b00, 32'h0};
      tbl[2]  = '{1'b0, 32'h40000010, 32'h0,        4'h0, 2'b00, 32'h11FF33FF};
      tbl[3]  = '{1'b1, 32'h40000013, 32'hA5A5A5A5, 4'h2, 2'b00, 32'h0};
      tbl[4]  = '{1'b0, 32'h40000012, 32'h0,        4'h0, 2'b00, 32'h11FFA5FF};
      tbl[5]  = '{1'b1, 32'h40001000, 32'hDEADBEEF, 4'hF, 2'b10, 32'h0};
      tbl[6]  = '{1'b0, 32'h3FFFFFFC, 32'h0,        4'h0, 2'b10, 32'h0};
      tbl[7]  = '{1'b0, 32'h40000000, 32'h0,        4'h0, 2'b00, 32'hAA000000};
      tbl[8]  = '{1'b1, 32'h40000FFC, 32'hCAFEF00D, 4'hF, 2'b00, 32'h0};
      tbl[9]  = '{1'b0, 32'h40000FFF, 32'h0,        4'h0, 2'b00, 32'hCAFEF00D};
      tbl[10] = '{1'b1, 32'hFFFFFFFC, 32'h12345678, 4'hF, 2'b10, 32'h0};
      tbl[11] = '{1'b0, 32'h40001000, 32'h0,        4'h0, 2'b10, 32'h0};
      tbl[12] = '{1'b1, 32'h40000004, 32'h00000000, 4'h0, 2'b00, 32'h0};
      tbl[13] = '{1'b0, 32'h40000004, 32'h0,        4'h0, 2'b00, 32'hAA000001};

      repeat (3) @(negedge clk);
      check("reset_outputs", 64'({awready, wready, bvalid, bresp, arready, rvalid, rresp, rdata, err_cnt}), 64'd0);
      rst = 1'b0;
      @(negedge clk);
      check("ready_after_reset", 64'({awready, wready, arready, bvalid, rvalid}), 64'(5'b11100));

      for (int i = 0; i < DEPTH; i++) begin
         do_write(BASE + 32'(4 * i), 32'hAA000000 + 32'(i), 4'hF, 0, 0, 0, r);
         exp_r = ref_write(BASE + 32'(4 * i), 32'hAA000000 + 32'(i), 4'hF);
         check("fill_bresp", 64'(r), 64'(exp_r));
      end
      for (int i = 0; i < DEPTH; i++) begin
         do_read(BASE + 32'(4 * i), 0, d, r);
         check("readback_data", 64'(d), 64'(32'hAA000000 + 32'(i)));
         check("readback_rresp", 64'(r), 64'd0);
      end
      check("fill_err_cnt", 64'(err_cnt), 64'd0);

      for (int i = 0; i < 14; i++) begin
         if (tbl[i].is_wr) begin
            do_write(tbl[i].addr, tbl[i].data, tbl[i].strb, 0, 0, 0, r);
            exp_r = ref_write(tbl[i].addr, tbl[i].data, tbl[i].strb);
            check("tbl_bresp", 64'(r), 64'(tbl[i].exp_resp));
         end else begin
            do_read(tbl[i].addr, 0, d, r);
            ref_read(tbl[i].addr, exp_d, exp_r);
            check("tbl_rdata", 64'(d), 64'(tbl[i].exp_rdata));
            check("tbl_rresp", 64'(r), 64'(tbl[i].exp_resp));
         end
         check("tbl_err_cnt", 64'(err_cnt), 64'(ref_err));
      end

      // Ordering: W three cycles ahead of AW, then AW two cycles ahead of W.
      do_write(BASE + 32'h20, 32'h0BADF00D, 4'hF, 3, 0, 0, r);
      exp_r = ref_write(BASE + 32'h20, 32'h0BADF00D, 4'hF);
      check("w_first_bresp", 64'(r), 64'(exp_r));
      do_write(BASE + 32'h24, 32'h600DCAFE, 4'hC, 0, 2, 0, r);
      exp_r = ref_write(BASE + 32'h24, 32'h600DCAFE, 4'hC);
      check("aw_first_bresp", 64'(r), 64'(exp_r));
      do_read(BASE + 32'h20, 0, d, r);
      check("w_first_readback", 64'(d), 64'(32'h0BADF00D));
      do_read(BASE + 32'h24, 0, d, r);
      check("aw_first_readback", 64'(d), 64'(32'h600D0009));

      // Backpressure: responses held for five cycles with ready low.
      do_write(BASE + 32'h28, 32'h5A5A5A5A, 4'hF, 0, 0, 5, r);
      exp_r = ref_write(BASE + 32'h28, 32'h5A5A5A5A, 4'hF);
      check("bp_bresp", 64'(r), 64'(exp_r));
      do_read(BASE + 32'h28, 5, d, r);
      check("bp_rdata", 64'(d), 64'(32'h5A5A5A5A));

      // Write commit and read sample on the same edge: read sees old word.
      old_d = ref_mem[12];
      fork
         do_write(BASE + 32'h30, 32'h13572468, 4'hF, 0, 0, 0, r);
         do_read(BASE + 32'h30, 0, d, r2);
      join
      exp_r = ref_write(BASE + 32'h30, 32'h13572468, 4'hF);
      check("same_edge_old_data", 64'(d), 64'(old_d));
      do_read(BASE + 32'h30, 0, d, r);
      check("same_edge_new_data", 64'(d), 64'(32'h13572468));

      // B and R errors on the same edge count twice.
      e0 = ref_err;
      fork
         do_write(32'h50000000, 32'h1, 4'hF, 0, 0, 0, r);
         do_read(32'h30000000, 0, d, r2);
      join
      exp_r = ref_write(32'h50000000, 32'h1, 4'hF);
      ref_read(32'h30000000, exp_d, exp_r);
      check("dual_err_resp", 64'({r, r2, d}), 64'({2'b10, 2'b10, 32'h0}));
      check("dual_err_cnt", 64'(err_cnt), 64'(e0 + 2));

      for (int n = 0; n < 400; n++) begin
         case ($urandom_range(0, 9))
            0:       a = BASE - 32'($urandom_range(1, 8));
            1:       a = BASE + 32'(DEPTH * 4) + 32'($urandom_range(0, 7));
            2:       a = $urandom;
            default: a = BASE + 32'($urandom_range(0, DEPTH * 4 - 1));
         endcase
         if ($urandom_range(0, 1) == 1) begin
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            do_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), r);
            exp_r = ref_write(a, d, s);
            check("rand_bresp", 64'(r), 64'(exp_r));
         end else begin
            do_read(a, $urandom_range(0, 2), d, r);
            ref_read(a, exp_d, exp_r);
            check("rand_rdata", 64'(d), 64'(exp_d));
            check("rand_rresp", 64'(r), 64'(exp_r));
         end
      end
      check("rand_err_cnt", 64'(err_cnt), 64'(ref_err));

      // Reset while the write is counting down in W_WAIT.
      old_d = ref_mem[16];
      check("rst_pre_ready", 64'({awready, wready}), 64'(2'b11));
      awaddr = BASE + 32'h40; wdata = 32'h87654321; wstrb = 4'hF;
      awvalid = 1'b1; wvalid = 1'b1;
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("rst_mid_outputs", 64'({awready, wready, bvalid, arready, rvalid, err_cnt}), 64'd0);
      ref_err = 0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      saw_b = 0;
      for (int i = 0; i < WAIT + 4; i++) begin
         @(negedge clk);
         if (bvalid) saw_b = 1;
      end
      check("rst_no_bvalid", 64'(saw_b), 64'd0);
      do_read(BASE + 32'h40, 0, d, r);
      check("rst_word_unchanged", 64'(d), 64'(old_d));
      check("rst_err_cnt", 64'(err_cnt), 64'(ref_err));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
